// File: rtl/sponge_absorb_stream_pkg.sv
// Shared types and constants for the streaming sponge absorb controller.
package sponge_absorb_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_START,
        ST_PERM,
        ST_OUT
    } absorb_state_t;

    // Tag sent to the permutation on the final call, MSB first.
    typedef struct packed {
        logic [1:0] domain;
        logic       finalize;
        logic       padded;
    } ds_tag_t;

    localparam int unsigned DS_TAG_W = $bits(ds_tag_t);
    localparam logic [7:0]  PAD_BYTE = 8'h01;

    function automatic ds_tag_t make_tag(input logic [1:0] domain,
                                         input logic       finalize,
                                         input logic       padded);
        ds_tag_t t;
        t.domain   = domain;
        t.finalize = finalize;
        t.padded   = padded;
        return t;
    endfunction

endpackage

// File: rtl/sponge_absorb_stream_pad_block.sv
// Combinational last-block padding: byte mask, pad-byte insertion and padded flag.
module sponge_pad_block
    import sponge_absorb_stream_pkg::*;
#(
    parameter int RATE_W = 128,
    parameter int NB_W   = $clog2(RATE_W/8) + 1
) (
    input  logic [RATE_W-1:0] data,
    input  logic [NB_W-1:0]   bytes,
    input  logic              last,
    output logic [RATE_W-1:0] block,
    output logic              padded
);

    localparam int unsigned NBYTES = RATE_W / 8;

    logic [NB_W-1:0] n;

    always_comb begin
        n      = (bytes > NB_W'(NBYTES)) ? NB_W'(NBYTES) : bytes;
        block  = data;
        padded = 1'b0;
        if (last) begin
            padded = (n != NB_W'(NBYTES));
            // Bytes at and above n are cleared; byte n carries the pad marker.
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (k >= 32'(n)) begin
                    block[8*k +: 8] = (k == 32'(n)) ? PAD_BYTE : 8'h00;
                end
            end
        end
    end

endmodule

// File: rtl/sponge_absorb_stream.sv
// Streaming sponge absorb controller: XORs padded rate blocks into a held state
// and drives an external permutation core once per block.
module sponge_absorb_stream
    import sponge_absorb_stream_pkg::*;
#(
    parameter int STATE_W = 384,
    parameter int RATE_W  = 128,
    parameter int DS_W    = 4,
    parameter int NB_W    = $clog2(RATE_W/8) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [STATE_W-1:0] init_state,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RATE_W-1:0]  in_data,
    input  logic               in_last,
    input  logic [NB_W-1:0]    in_bytes,
    input  logic [1:0]         domain,
    input  logic               finalize,
    output logic               perm_start,
    output logic [STATE_W-1:0] perm_state,
    output logic [DS_W-1:0]    perm_ds,
    input  logic [STATE_W-1:0] perm_result,
    input  logic               perm_done,
    output logic               out_valid,
    output logic [STATE_W-1:0] out_state,
    input  logic               out_ready
);

    absorb_state_t      fsm;
    logic [STATE_W-1:0] state_q;
    logic               last_q;
    logic [DS_W-1:0]    ds_q;
    logic [RATE_W-1:0]  pad_block;
    logic               pad_flag;

    sponge_pad_block #(
        .RATE_W (RATE_W),
        .NB_W   (NB_W)
    ) u_pad (
        .data   (in_data),
        .bytes  (in_bytes),
        .last   (in_last),
        .block  (pad_block),
        .padded (pad_flag)
    );

    // The state register is only rewritten on transfer or perm_done, which
    // keeps perm_state stable for the whole permutation.
    assign perm_state = state_q;
    assign out_state  = state_q;
    assign perm_ds    = ds_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm        <= ST_IDLE;
            state_q    <= '0;
            last_q     <= 1'b0;
            ds_q       <= '0;
            in_ready   <= 1'b0;
            perm_start <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            perm_start <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    if (init) begin
                        state_q  <= init_state;
                        in_ready <= 1'b1;
                        fsm      <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid && in_ready) begin
                        state_q[RATE_W-1:0] <= state_q[RATE_W-1:0] ^ pad_block;
                        last_q     <= in_last;
                        ds_q       <= in_last ? DS_W'(make_tag(domain, finalize, pad_flag)) : '0;
                        in_ready   <= 1'b0;
                        perm_start <= 1'b1;
                        fsm        <= ST_START;
                    end
                end
                ST_START: begin
                    fsm <= ST_PERM;
                end
                ST_PERM: begin
                    if (perm_done) begin
                        state_q <= perm_result;
                        if (last_q) begin
                            out_valid <= 1'b1;
                            fsm       <= ST_OUT;
                        end else begin
                            in_ready <= 1'b1;
                            fsm      <= ST_ACCEPT;
                        end
                    end
                end
                ST_OUT: begin
                    if (init) begin
                        out_valid <= 1'b0;
                        state_q   <= init_state;
                        in_ready  <= 1'b1;
                        fsm       <= ST_ACCEPT;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= ST_IDLE;
                    end
                end
                default: begin
                    fsm <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sponge_absorb_stream.sv
// Directed self-checking bench for sponge_absorb_stream with a rotate-left-1 stub permutation.
module tb_sponge_absorb_stream;

    localparam int STATE_W = 384;
    localparam int RATE_W  = 128;
    localparam int DS_W    = 4;
    localparam int NB_W    = 5;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               init = 1'b0;
    logic [STATE_W-1:0] init_state = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [RATE_W-1:0]  in_data = '0;
    logic               in_last = 1'b0;
    logic [NB_W-1:0]    in_bytes = '0;
    logic [1:0]         domain = '0;
    logic               finalize = 1'b0;
    logic               perm_start;
    logic [STATE_W-1:0] perm_state;
    logic [DS_W-1:0]    perm_ds;
    logic [STATE_W-1:0] perm_result;
    logic               perm_done;
    logic               out_valid;
    logic [STATE_W-1:0] out_state;
    logic               out_ready = 1'b0;

    int tests = 0;
    int failed = 0;

    sponge_absorb_stream #(
        .STATE_W (STATE_W),
        .RATE_W  (RATE_W),
        .DS_W    (DS_W),
        .NB_W    (NB_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .init_state  (init_state),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .domain      (domain),
        .finalize    (finalize),
        .perm_start  (perm_start),
        .perm_state  (perm_state),
        .perm_ds     (perm_ds),
        .perm_result (perm_result),
        .perm_done   (perm_done),
        .out_valid   (out_valid),
        .out_state   (out_state),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [STATE_W-1:0] rotl1(input logic [STATE_W-1:0] x);
        return {x[STATE_W-2:0], x[STATE_W-1]};
    endfunction

    // Stub permutation: captures input on start, pulses done a few cycles later.
    logic [STATE_W-1:0] cap = '0;
    int unsigned        cnt = 0;
    logic               stub_done = 1'b0;
    logic               force_done = 1'b0;
    int                 nstarts = 0;
    logic [DS_W-1:0]    ds_log [0:7];

    assign perm_result = rotl1(cap);
    assign perm_done   = stub_done | force_done;

    always @(posedge clk) begin
        stub_done <= (cnt == 1);
        if (perm_start) begin
            cap                  <= perm_state;
            cnt                  <= 3;
            ds_log[nstarts % 8]  <= perm_ds;
            nstarts              <= nstarts + 1;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; init = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        force_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_init(input logic [STATE_W-1:0] v);
        init = 1'b1; init_state = v;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic send_block(input logic [RATE_W-1:0] d, input logic last, input logic [NB_W-1:0] nb,
                              input logic [1:0] dom, input logic fin, output logic ok);
        ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb; domain = dom; finalize = fin;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if ({in_ready, out_valid, perm_start} !== 3'b000) begin
            failed++; $display("FAIL reset_ctrl: got %b expected 000", {in_ready, out_valid, perm_start});
        end
        tests++;
        if (perm_ds !== '0 || out_state !== '0 || perm_state !== '0) begin
            failed++; $display("FAIL reset_data: ds %h out %h expected zero", perm_ds, out_state);
        end
    endtask

    task automatic test_full_block();
        logic ok;
        logic [RATE_W-1:0] aa;
        aa = {16{8'hAA}};
        apply_reset();
        do_init('0);
        send_block(aa, 1'b1, 5'd16, 2'b00, 1'b0, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL full_handshake: got timeout expected transfer"); end
        tests++;
        if (perm_start !== 1'b1 || in_ready !== 1'b0) begin
            failed++; $display("FAIL full_start: got start=%b ready=%b expected 1 0", perm_start, in_ready);
        end
        tests++;
        if (perm_state[RATE_W-1:0] !== aa || perm_ds !== 4'b0000) begin
            failed++; $display("FAIL full_rate: got %h ds %b expected %h ds 0000", perm_state[RATE_W-1:0], perm_ds, aa);
        end
        wait_out(ok);
        tests++;
        if (!ok || out_state !== rotl1({256'h0, aa})) begin
            failed++; $display("FAIL full_out: got %h expected %h", out_state, rotl1({256'h0, aa}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failed++; $display("FAIL full_drain: got valid=%b ready=%b expected 0 0", out_valid, in_ready);
        end
    endtask

    task automatic test_partial_block();
        logic ok;
        apply_reset();
        do_init('0);
        send_block({16{8'hFF}}, 1'b1, 5'd5, 2'b01, 1'b0, ok);
        tests++;
        if (!ok || perm_state[RATE_W-1:0] !== 128'h0000_0000_0000_0000_0000_01FF_FFFF_FFFF) begin
            failed++; $display("FAIL partial_rate: got %h expected %h", perm_state[RATE_W-1:0], 128'h01FF_FFFF_FFFF);
        end
        tests++;
        if (perm_ds !== 4'b0101) begin
            failed++; $display("FAIL partial_ds: got %b expected 0101", perm_ds);
        end
    endtask

    task automatic test_empty_block();
        logic ok;
        apply_reset();
        do_init('0);
        send_block({16{8'hC3}}, 1'b1, 5'd0, 2'b10, 1'b1, ok);
        tests++;
        if (!ok || perm_state[RATE_W-1:0] !== 128'h1 || perm_ds !== 4'b1011) begin
            failed++; $display("FAIL empty_block: got %h ds %b expected 1 ds 1011", perm_state[RATE_W-1:0], perm_ds);
        end
        wait_out(ok);
        tests++;
        if (!ok || out_state !== {{(STATE_W-2){1'b0}}, 2'b10}) begin
            failed++; $display("FAIL empty_out: got %h expected 2", out_state);
        end
    endtask

    task automatic test_saturate();
        logic ok;
        logic [RATE_W-1:0] d;
        d = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        apply_reset();
        do_init('0);
        send_block(d, 1'b1, 5'd20, 2'b11, 1'b1, ok);
        tests++;
        if (!ok || perm_state[RATE_W-1:0] !== d || perm_ds !== 4'b1110) begin
            failed++; $display("FAIL saturate: got %h ds %b expected %h ds 1110", perm_state[RATE_W-1:0], perm_ds, d);
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        logic all_ok;
        int s0;
        int bad;
        logic [STATE_W-1:0] k, exp;
        logic [RATE_W-1:0] b0, b1;
        k  = {{32{4'h1}}, {32{4'h2}}, {32{4'h3}}};
        b0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
        b1 = ~b0;
        exp = rotl1(rotl1(rotl1(k ^ {256'h0, b0}) ^ {256'h0, b1}) ^ {256'h0, 128'h0155_5555});
        apply_reset();
        s0 = nstarts;
        all_ok = 1'b1;
        do_init(k);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_block(b0, 1'b0, 5'd0, 2'b11, 1'b1, ok); all_ok &= ok;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        send_block(b1, 1'b0, 5'd3, 2'b11, 1'b1, ok); all_ok &= ok;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        send_block({16{8'h55}}, 1'b1, 5'd3, 2'b11, 1'b0, ok); all_ok &= ok;
        wait_out(ok); all_ok &= ok;
        tests++;
        if (!all_ok || out_state !== exp) begin
            failed++; $display("FAIL b2b_state: got %h expected %h", out_state, exp);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_state !== exp || in_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin failed++; $display("FAIL b2b_hold: got %0d unstable cycles expected 0", bad); end
        tests++;
        if (nstarts - s0 != 3) begin failed++; $display("FAIL b2b_starts: got %0d expected 3", nstarts - s0); end
        tests++;
        if (ds_log[s0 % 8] !== 4'b0000 || ds_log[(s0 + 1) % 8] !== 4'b0000 || ds_log[(s0 + 2) % 8] !== 4'b1101) begin
            failed++; $display("FAIL b2b_ds: got %b %b %b expected 0000 0000 1101",
                               ds_log[s0 % 8], ds_log[(s0 + 1) % 8], ds_log[(s0 + 2) % 8]);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_perm();
        logic ok;
        int s0;
        int bad;
        apply_reset();
        do_init({384{1'b1}});
        send_block({16{8'h3C}}, 1'b0, 5'd0, 2'b00, 1'b0, ok);
        @(negedge clk);
        s0 = nstarts;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            force_done = (i == 4);
            @(negedge clk);
            if (perm_start !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || perm_ds !== '0 || out_state !== '0) bad++;
        end
        force_done = 1'b0;
        tests++;
        if (!ok || bad != 0) begin failed++; $display("FAIL rst_perm_outputs: got %0d bad cycles expected 0", bad); end
        tests++;
        if (nstarts != s0) begin failed++; $display("FAIL rst_perm_starts: got %0d expected %0d", nstarts, s0); end
        do_init({3{128'hA5}});
        tests++;
        if (in_ready !== 1'b1 || perm_state !== {3{128'hA5}}) begin
            failed++; $display("FAIL rst_perm_idle: got ready=%b state %h expected 1", in_ready, perm_state);
        end
    endtask

    task automatic test_init_ignored();
        logic ok, all_ok;
        logic [RATE_W-1:0] d, e;
        logic [STATE_W-1:0] z, exp;
        d = 128'hCAFEBABE_00000000_12345678_9ABCDEF0;
        e = 128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF;
        z = {128'h7, 128'h8, 128'h9};
        exp = rotl1({256'h0, d}) ^ {256'h0, e};
        apply_reset();
        do_init('0);
        init = 1'b1; init_state = {384{1'b1}};
        @(negedge clk);
        init = 1'b0;
        send_block(d, 1'b0, 5'd0, 2'b00, 1'b0, ok);
        tests++;
        if (!ok || perm_state !== {256'h0, d}) begin
            failed++; $display("FAIL init_accept: got %h expected %h", perm_state, {256'h0, d});
        end
        init = 1'b1; init_state = {384{1'b1}};
        @(negedge clk);
        @(negedge clk);
        init = 1'b0;
        send_block(e, 1'b1, 5'd16, 2'b00, 1'b0, ok);
        tests++;
        if (!ok || perm_state !== exp) begin
            failed++; $display("FAIL init_perm: got %h expected %h", perm_state, exp);
        end
        wait_out(all_ok);
        init = 1'b1; init_state = z; out_ready = 1'b1;
        @(negedge clk);
        init = 1'b0; out_ready = 1'b0;
        tests++;
        if (!all_ok || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++; $display("FAIL init_out: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        send_block('0, 1'b0, 5'd0, 2'b00, 1'b0, ok);
        tests++;
        if (!ok || perm_state !== z) begin
            failed++; $display("FAIL init_reload: got %h expected %h", perm_state, z);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_block();
        test_partial_block();
        test_empty_block();
        test_saturate();
        test_back_to_back();
        test_reset_mid_perm();
        test_init_ignored();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
